// File: rtl/bf_pkg.sv
// Shared bfX definitions: bracket codes, memory geometry, scan direction
// encoding and the bracket scanner state type.
package bf_pkg;

   localparam int          ADDR_W   = 16;
   localparam int          MEM_LAST = 511;
   localparam logic [7:0]  OPEN_CH  = 8'h5B;
   localparam logic [7:0]  CLOSE_CH = 8'h5D;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_BWD = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_e;

endpackage

// File: rtl/bf_bracket_scanner.sv
// Finds the bracket matching the one at start_addr by streaming program
// memory one byte per cycle and tracking nesting depth.
module bf_bracket_scanner #(
   parameter int                ADDR_W   = bf_pkg::ADDR_W,
   parameter int                DATA_W   = 8,
   parameter int                DEPTH_W  = 8,
   parameter int                MEM_LAST = bf_pkg::MEM_LAST,
   parameter logic [DATA_W-1:0] OPEN_CH  = DATA_W'(bf_pkg::OPEN_CH),
   parameter logic [DATA_W-1:0] CLOSE_CH = DATA_W'(bf_pkg::CLOSE_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              dir,
   input  logic [ADDR_W-1:0] start_addr,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] match_addr,
   output logic              mem_active,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   import bf_pkg::*;

   localparam logic [ADDR_W-1:0]  LAST_A    = ADDR_W'(MEM_LAST);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

   scan_state_e         state, state_d;
   logic                dir_q, dir_d;
   logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
   logic [DEPTH_W-1:0]  depth, depth_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_active_q, mem_active_d;
   logic                vld_p1, vld_p1_d;
   logic [ADDR_W-1:0]   chk_addr_p1, chk_addr_p1_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic [ADDR_W-1:0]   match_addr_q, match_addr_d;

   logic                finish, fin_err;
   logic [ADDR_W-1:0]   last_addr;
   logic [DATA_W-1:0]   same_ch, opp_ch;

   function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a,
                                                   input logic d);
      return (d == DIR_BWD) ? a - ADDR_W'(1) : a + ADDR_W'(1);
   endfunction

   function automatic logic depth_wraps(input logic [DEPTH_W-1:0] dp);
      return dp == DEPTH_MAX;
   endfunction

   always_comb begin
      state_d       = state;
      dir_d         = dir_q;
      start_addr_d  = start_addr_q;
      depth_d       = depth;
      mem_addr_d    = mem_addr_q;
      mem_active_d  = mem_active_q;
      vld_p1_d      = 1'b0;
      chk_addr_p1_d = chk_addr_p1;
      busy_d        = busy_q;
      done_d        = 1'b0;
      error_d       = error_q;
      match_addr_d  = match_addr_q;
      finish        = 1'b0;
      fin_err       = 1'b0;
      last_addr     = (dir_q == DIR_BWD) ? '0 : LAST_A;
      same_ch       = (dir_q == DIR_BWD) ? CLOSE_CH : OPEN_CH;
      opp_ch        = (dir_q == DIR_BWD) ? OPEN_CH : CLOSE_CH;

      unique case (state)
         ST_IDLE: begin
            if (start) begin
               dir_d        = dir;
               start_addr_d = start_addr;
               // A bracket sitting on the memory boundary cannot have a partner
               if ((dir == DIR_FWD && start_addr >= LAST_A) ||
                   (dir == DIR_BWD && start_addr == '0)) begin
                  done_d       = 1'b1;
                  error_d      = 1'b1;
                  match_addr_d = start_addr;
               end else begin
                  state_d      = ST_SCAN;
                  busy_d       = 1'b1;
                  depth_d      = DEPTH_W'(1);
                  mem_active_d = 1'b1;
                  mem_addr_d   = addr_step(start_addr, dir);
               end
            end
         end
         ST_SCAN: begin
            // p0: issue side
            vld_p1_d      = mem_active_q;
            chk_addr_p1_d = mem_addr_q;
            if (mem_active_q) begin
               if (mem_addr_q == last_addr) mem_active_d = 1'b0;
               else                         mem_addr_d   = addr_step(mem_addr_q, dir_q);
            end
            // p1: check side, byte returned for chk_addr_p1
            if (vld_p1) begin
               if (mem_rdata == same_ch) begin
                  if (depth_wraps(depth)) begin
                     finish  = 1'b1;
                     fin_err = 1'b1;
                  end else begin
                     depth_d = depth + DEPTH_W'(1);
                  end
               end else if (mem_rdata == opp_ch) begin
                  depth_d = depth - DEPTH_W'(1);
                  if (depth_d == '0) finish = 1'b1;
               end
               if (!finish && chk_addr_p1 == last_addr && depth_d != '0) begin
                  finish  = 1'b1;
                  fin_err = 1'b1;
               end
            end
            if (finish) begin
               state_d      = ST_IDLE;
               busy_d       = 1'b0;
               done_d       = 1'b1;
               error_d      = fin_err;
               match_addr_d = fin_err ? start_addr_q : chk_addr_p1;
               mem_active_d = 1'b0;
               mem_addr_d   = '0;
               vld_p1_d     = 1'b0;
               depth_d      = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         dir_q        <= DIR_FWD;
         start_addr_q <= '0;
         depth        <= '0;
         mem_addr_q   <= '0;
         mem_active_q <= 1'b0;
         vld_p1       <= 1'b0;
         chk_addr_p1  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         match_addr_q <= '0;
      end else begin
         state        <= state_d;
         dir_q        <= dir_d;
         start_addr_q <= start_addr_d;
         depth        <= depth_d;
         mem_addr_q   <= mem_addr_d;
         mem_active_q <= mem_active_d;
         vld_p1       <= vld_p1_d;
         chk_addr_p1  <= chk_addr_p1_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         match_addr_q <= match_addr_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign match_addr = match_addr_q;
   assign mem_active = mem_active_q;
   assign mem_read   = 1'b1;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = '0;

endmodule

// File: tb/tb_bf_bracket_scanner.sv
// Bench for bf_bracket_scanner: behavioural memory responder plus a
// depth-counting reference scan over the same memory image.
module tb_bf_bracket_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        dir = 1'b0;
   logic [15:0] start_addr = '0;
   logic        busy, done, error, mem_active, mem_read;
   logic [15:0] match_addr, mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;

   logic [7:0]  mem [0:511];
   int          checks = 0;
   int          errors = 0;
   int          oob = 0;
   int          act_cnt;
   logic [15:0] addr_log [$];

   bf_bracket_scanner dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dir        (dir),
      .start_addr (start_addr),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .match_addr (match_addr),
      .mem_active (mem_active),
      .mem_read   (mem_read),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // memory responder: request sampled at posedge, data valid after it
   always @(posedge clk) begin
      if (mem_active) begin
         if (mem_addr > 16'd511) begin
            oob <= oob + 1;
            mem_rdata <= 8'h00;
         end else begin
            mem_rdata <= mem[mem_addr[8:0]];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk the image from the start bracket counting nesting depth.
   // lat = edges after the start-sampling edge at which done is registered.
   function automatic void ref_scan(input logic d, input int sa,
                                    output logic e, output int m, output int lat);
      int depth, a, step, last, k;
      logic [7:0] same, opp;
      if ((d == 1'b0 && sa >= 511) || (d == 1'b1 && sa == 0)) begin
         e = 1'b1; m = sa; lat = 0;
         return;
      end
      step  = d ? -1 : 1;
      last  = d ? 0 : 511;
      same  = d ? 8'h5D : 8'h5B;
      opp   = d ? 8'h5B : 8'h5D;
      depth = 1;
      a     = sa;
      while (1) begin
         a = a + step;
         k = d ? sa - a : a - sa;
         if (mem[a] == same) begin
            depth++;
            if (depth > 255) begin e = 1'b1; m = sa; lat = k + 1; return; end
         end else if (mem[a] == opp) begin
            depth--;
            if (depth == 0) begin e = 1'b0; m = a; lat = k + 1; return; end
         end
         if (a == last) begin e = 1'b1; m = sa; lat = k + 1; return; end
      end
   endfunction

   task automatic do_scan(input logic d, input int sa, input int intr_at,
                          output int lat_o, output logic e_o,
                          output logic [15:0] m_o, output logic da_o);
      act_cnt = 0;
      addr_log.delete();
      lat_o = -1; e_o = 1'b0; m_o = '0; da_o = 1'b0;
      @(negedge clk);
      dir = d; start_addr = 16'(sa); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 700; n++) begin
         if (mem_active) begin
            act_cnt++;
            addr_log.push_back(mem_addr);
         end
         if (done) begin
            lat_o = n; e_o = error; m_o = match_addr;
            break;
         end
         if (n == intr_at) begin
            start = 1'b1; dir = ~d; start_addr = 16'h0010;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      @(posedge clk); #1;
      da_o = done;
   endtask

   task automatic run_and_check(input string tag, input logic d, input int sa,
                                input int intr_at);
      logic e_exp, e_obs, da;
      int m_exp, lat_exp, lat_obs;
      logic [15:0] m_obs;
      ref_scan(d, sa, e_exp, m_exp, lat_exp);
      do_scan(d, sa, intr_at, lat_obs, e_obs, m_obs, da);
      chk({tag, "_latency"}, lat_obs, lat_exp);
      chk({tag, "_error"}, {31'd0, e_obs}, {31'd0, e_exp});
      chk({tag, "_match"}, {16'd0, m_obs}, m_exp);
      chk({tag, "_done_1cyc"}, {31'd0, da}, 32'd0);
   endtask

   initial begin
      logic [15:0] amax;
      int done_cnt, sa, r;

      for (int i = 0; i < 512; i++) mem[i] = 8'h2E;
      mem['h10] = "["; mem['h11] = "+"; mem['h12] = "]";
      mem['h20] = "["; mem['h21] = "["; mem['h22] = "-";
      mem['h23] = "]"; mem['h24] = ">"; mem['h25] = "]";
      mem['h1F0] = "[";
      for (int i = 'h1F1; i < 512; i++) mem[i] = "+";

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_mem_active", {31'd0, mem_active}, 32'd0);
      chk("rst_match_addr", {16'd0, match_addr}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("mem_read_const", {31'd0, mem_read}, 32'd1);
      chk("mem_wdata_const", {24'd0, mem_wdata}, 32'd0);
      rst_n = 1'b1;

      run_and_check("fwd_simple", 1'b0, 'h10, -1);
      chk("fwd_simple_match_addr", {16'd0, match_addr}, 32'h12);
      run_and_check("fwd_nested", 1'b0, 'h20, -1);
      run_and_check("bwd_nested", 1'b1, 'h25, -1);
      chk("bwd_first_addr", {16'd0, addr_log[0]}, 32'h24);
      chk("bwd_second_addr", {16'd0, addr_log[1]}, 32'h23);

      run_and_check("unmatched_top", 1'b0, 'h1F0, -1);
      amax = '0;
      foreach (addr_log[i]) if (addr_log[i] > amax) amax = addr_log[i];
      chk("unmatched_max_addr", {16'd0, amax}, 32'h1FF);

      run_and_check("edge_bwd_zero", 1'b1, 0, -1);
      chk("edge_bwd_no_access", act_cnt, 0);
      run_and_check("edge_fwd_last", 1'b0, 511, -1);
      chk("edge_fwd_no_access", act_cnt, 0);
      run_and_check("fwd_near_top", 1'b0, 'h1FE, -1);

      // reset two cycles into a long scan
      @(negedge clk);
      dir = 1'b0; start_addr = 16'h01F0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_mem_active", {31'd0, mem_active}, 32'd0);
      chk("abort_match_addr", {16'd0, match_addr}, 32'd0);
      done_cnt = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);

      run_and_check("busy_start_ignored", 1'b0, 'h20, 2);
      chk("busy_match_kept", {16'd0, match_addr}, 32'h25);

      for (int i = 0; i <= 'h100; i++) mem[i] = "[";
      run_and_check("depth_overflow", 1'b0, 0, -1);

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 512; i++) begin
            r = $urandom_range(0, 9);
            mem[i] = (r < 3) ? 8'h5B : (r < 6) ? 8'h5D : (r < 8) ? 8'h2B : 8'h3E;
         end
         sa = $urandom_range(0, 511);
         while (mem[sa] != 8'h5B && mem[sa] != 8'h5D) sa = $urandom_range(0, 511);
         run_and_check("random", mem[sa] == 8'h5D, sa, -1);
      end

      chk("no_out_of_range_addr", oob, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
